// File: rtl/shift_register_seq_pkg.sv
// Shared types for the sequenced shift register.
// Shift modes and FSM states used by the top level and the shift step.
package shift_pkg;

    typedef enum logic [1:0] {
        SRL = 2'b00,
        SLL = 2'b01,
        SRA = 2'b10,
        ROR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_register_seq_shift_step.sv
// One combinational shift step for a WIDTH-bit word.
// Also reports the bit the selected mode shifts out.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  shift_mode_t      mode,
    input  logic             shift_in,
    output logic [WIDTH-1:0] next_d,
    output logic             shift_out
);

    always_comb begin
        next_d = d;
        unique case (mode)
            SRL:     next_d = {shift_in, d[WIDTH-1:1]};
            SLL:     next_d = {d[WIDTH-2:0], shift_in};
            SRA:     next_d = {d[WIDTH-1], d[WIDTH-1:1]};
            ROR:     next_d = {d[0], d[WIDTH-1:1]};
            default: next_d = d;
        endcase
    end

    assign shift_out = (mode == SLL) ? d[WIDTH-1] : d[0];

endmodule

// File: rtl/shift_register_seq.sv
// WIDTH-bit shift register with load, single shift and a
// self-counting multi-shift sequencer that pulses Done when finished.
module shift_register_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Shift_Enable,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    input  logic [1:0]       Mode,
    input  logic             Shift_In,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Shift_Out,
    output logic             Busy,
    output logic             Done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    shift_mode_t      mode_q, mode_d;

    shift_mode_t      eff_mode;
    logic [WIDTH-1:0] step_d;
    logic             step_out;

    // A running sequence must not see Mode changes on the port.
    assign eff_mode = (state_q == SHIFT) ? mode_q : shift_mode_t'(Mode);

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .d        (data_q),
        .mode     (eff_mode),
        .shift_in (Shift_In),
        .next_d   (step_d),
        .shift_out(step_out)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (Load) begin
                    data_d = Data_In;
                end else if (Start) begin
                    if (Count != '0) begin
                        mode_d  = shift_mode_t'(Mode);
                        rem_d   = Count;
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end else if (Shift_Enable) begin
                    data_d = step_d;
                end
            end
            SHIFT: begin
                data_d = step_d;
                rem_d  = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= SRL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign Data_Out  = data_q;
    assign Shift_Out = step_out;
    assign Busy      = (state_q == SHIFT);
    assign Done      = (state_q == DONE);

endmodule
